// File: rtl/fxp_pkg.sv
// fxp_pkg -- shared fixed-point helpers for the IIR datapath blocks.
// Holds the rounding-mode encodings and a constant max() used when
// deriving internal full-precision widths from parameters.
package fxp_pkg;

    localparam int RND_FLOOR      = 0;
    localparam int RND_HALF_UP    = 1;
    localparam int RND_CONVERGENT = 2;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/fxp_sum_pipe_if.sv
// fxp_sum_pipe_if -- handshake/data bundle for fxp_sum_pipe.
//   enb        clock enable (freezes the whole pipe when 0)
//   in_valid   in1/in2/sub carry a sample
//   in1, in2   signed operands (W_A, W_B bits)
//   sub        0: add, 1: in1 - in2
//   ovf_clr    clears ovf_sticky
//   out_valid  out1/ovf carry a result
//   out1       signed result (W_O bits)
//   ovf        current result overflowed W_O
//   ovf_sticky latched overflow flag
// master = sample source, slave = the adder.
interface fxp_sum_pipe_if #(
    parameter int W_A = 22,
    parameter int W_B = 39,
    parameter int W_O = 36
);
    logic           enb;
    logic           in_valid;
    logic [W_A-1:0] in1;
    logic [W_B-1:0] in2;
    logic           sub;
    logic           ovf_clr;
    logic           out_valid;
    logic [W_O-1:0] out1;
    logic           ovf;
    logic           ovf_sticky;

    modport master (
        output enb, in_valid, in1, in2, sub, ovf_clr,
        input  out_valid, out1, ovf, ovf_sticky
    );

    modport slave (
        input  enb, in_valid, in1, in2, sub, ovf_clr,
        output out_valid, out1, ovf, ovf_sticky
    );
endinterface

// File: rtl/fxp_round_sat.sv
// fxp_round_sat -- combinational narrowing of a signed full-precision value
// (WI bits, FI fraction bits) to W_O bits with F_O fraction bits.
//   i_x    signed input, sfix WI_En FI
//   o_y    rounded and wrapped/saturated result, sfix W_O_En F_O
//   o_ovf  rounded value did not fit in W_O bits
// RND_MODE selects floor / half-up / convergent, SAT selects wrap / clamp.
module fxp_round_sat
    import fxp_pkg::*;
#(
    parameter int WI       = 40,
    parameter int FI       = 28,
    parameter int W_O      = 36,
    parameter int F_O      = 27,
    parameter int RND_MODE = RND_HALF_UP,
    parameter int SAT      = 0
) (
    input  logic [WI-1:0]  i_x,
    output logic [W_O-1:0] o_y,
    output logic           o_ovf
);

    localparam int SH = (F_O >= FI) ? F_O - FI : 0;
    localparam int D  = (F_O >= FI) ? 0 : FI - F_O;
    // One guard bit on top of WI so the rounding increment can never wrap.
    localparam int WQ = WI + 1 + SH;
    localparam int WX = imax(WQ, W_O);

    localparam logic [W_O-1:0] MAX_V = {1'b0, {(W_O-1){1'b1}}};
    localparam logic [W_O-1:0] MIN_V = {1'b1, {(W_O-1){1'b0}}};

    logic [WQ-1:0] w_q;
    logic [WX-1:0] w_ext;
    logic          w_hi_ones;
    logic          w_hi_zeros;

    generate
        if (D == 0) begin : g_shl
            assign w_q = WQ'($signed(i_x)) << SH;
        end else begin : g_rnd
            localparam logic [D-1:0] HALF = D'(1) << (D - 1);
            logic [WI:0]  w_x1;
            logic [WI:0]  w_tr;
            logic [D-1:0] w_drop;
            logic         w_inc;

            assign w_x1   = (WI+1)'($signed(i_x));
            assign w_tr   = $signed(w_x1) >>> D;
            assign w_drop = i_x[D-1:0];

            always_comb begin
                w_inc = 1'b0;
                if (RND_MODE == RND_HALF_UP)
                    w_inc = w_drop[D-1];
                else if (RND_MODE == RND_CONVERGENT)
                    // exact tie onto an even kept value rounds down
                    w_inc = w_drop[D-1] & ~((w_drop == HALF) & ~i_x[D]);
            end

            assign w_q = w_tr + WQ'(w_inc);
        end
    endgenerate

    assign w_ext = WX'($signed(w_q));

    // Fits iff every bit from the W_O sign bit upward is a copy of the sign.
    assign w_hi_ones  = &w_ext[WX-1:W_O-1];
    assign w_hi_zeros = ~(|w_ext[WX-1:W_O-1]);
    assign o_ovf      = ~(w_hi_ones | w_hi_zeros);

    always_comb begin
        o_y = w_ext[W_O-1:0];
        if (o_ovf && SAT != 0)
            o_y = w_ext[WX-1] ? MIN_V : MAX_V;
    end

endmodule

// File: rtl/fxp_sum_pipe.sv
// fxp_sum_pipe -- two-stage pipelined fixed-point add/subtract.
//   clk    rising-edge clock
//   reset  asynchronous active-high reset, clears every register
//   bus    fxp_sum_pipe_if.slave: enb, in_valid, in1, in2, sub, ovf_clr in;
//          out_valid, out1, ovf, ovf_sticky out
// Stage 1 aligns both operands to a common fraction and adds exactly in WI
// bits; stage 2 rounds/narrows to W_O and registers the result and flags.
module fxp_sum_pipe
    import fxp_pkg::*;
#(
    parameter int W_A      = 22,
    parameter int F_A      = 14,
    parameter int W_B      = 39,
    parameter int F_B      = 28,
    parameter int W_O      = 36,
    parameter int F_O      = 27,
    parameter int RND_MODE = RND_HALF_UP,
    parameter int SAT      = 0
) (
    input logic            clk,
    input logic            reset,
    fxp_sum_pipe_if.slave  bus
);

    localparam int FI = imax(F_A, F_B);
    localparam int II = imax(W_A - F_A, W_B - F_B) + 1;
    localparam int WI = II + FI;

    logic [WI-1:0]  w_a;
    logic [WI-1:0]  w_b;
    logic [WI-1:0]  w_s;
    logic [W_O-1:0] w_y;
    logic           w_ovf;

    logic [WI-1:0]  r_s1;
    logic [1:0]     r_vld_pipe;   // [0]: stage-1 valid, [1]: out_valid
    logic [W_O-1:0] r_out1;
    logic           r_ovf;
    logic           r_sticky;

    // One extra integer bit in WI makes the add/sub exact.
    assign w_a = WI'($signed(bus.in1)) << (FI - F_A);
    assign w_b = WI'($signed(bus.in2)) << (FI - F_B);
    assign w_s = bus.sub ? (w_a - w_b) : (w_a + w_b);

    fxp_round_sat #(
        .WI(WI), .FI(FI), .W_O(W_O), .F_O(F_O),
        .RND_MODE(RND_MODE), .SAT(SAT)
    ) u_round_sat (
        .i_x  (r_s1),
        .o_y  (w_y),
        .o_ovf(w_ovf)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1       <= '0;
            r_vld_pipe <= '0;
            r_out1     <= '0;
            r_ovf      <= 1'b0;
            r_sticky   <= 1'b0;
        end else if (bus.enb) begin
            r_vld_pipe <= {r_vld_pipe[0], bus.in_valid};
            if (bus.in_valid)
                r_s1 <= w_s;
            if (r_vld_pipe[0])
                r_out1 <= w_y;
            r_ovf <= r_vld_pipe[0] & w_ovf;
            // a new overflow beats a simultaneous clear
            if (r_vld_pipe[0] & w_ovf)
                r_sticky <= 1'b1;
            else if (bus.ovf_clr)
                r_sticky <= 1'b0;
        end
    end

    assign bus.out_valid  = r_vld_pipe[1];
    assign bus.out1       = r_out1;
    assign bus.ovf        = r_ovf;
    assign bus.ovf_sticky = r_sticky;

endmodule

// File: tb/tb_fxp_sum_pipe.sv
module tb_fxp_sum_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        t_enb, t_vld, t_sub, t_clr;
    logic [21:0] t_in1;
    logic [38:0] t_in2;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    // four builds sharing one stimulus: default, floor, convergent, saturate
    fxp_sum_pipe_if b_def ();
    fxp_sum_pipe_if b_flr ();
    fxp_sum_pipe_if b_cnv ();
    fxp_sum_pipe_if b_sat ();

    assign b_def.enb = t_enb; assign b_def.in_valid = t_vld; assign b_def.in1 = t_in1;
    assign b_def.in2 = t_in2; assign b_def.sub = t_sub;      assign b_def.ovf_clr = t_clr;
    assign b_flr.enb = t_enb; assign b_flr.in_valid = t_vld; assign b_flr.in1 = t_in1;
    assign b_flr.in2 = t_in2; assign b_flr.sub = t_sub;      assign b_flr.ovf_clr = t_clr;
    assign b_cnv.enb = t_enb; assign b_cnv.in_valid = t_vld; assign b_cnv.in1 = t_in1;
    assign b_cnv.in2 = t_in2; assign b_cnv.sub = t_sub;      assign b_cnv.ovf_clr = t_clr;
    assign b_sat.enb = t_enb; assign b_sat.in_valid = t_vld; assign b_sat.in1 = t_in1;
    assign b_sat.in2 = t_in2; assign b_sat.sub = t_sub;      assign b_sat.ovf_clr = t_clr;

    fxp_sum_pipe #(.RND_MODE(1), .SAT(0)) u_def (.clk(clk), .reset(reset), .bus(b_def));
    fxp_sum_pipe #(.RND_MODE(0), .SAT(0)) u_flr (.clk(clk), .reset(reset), .bus(b_flr));
    fxp_sum_pipe #(.RND_MODE(2), .SAT(0)) u_cnv (.clk(clk), .reset(reset), .bus(b_cnv));
    fxp_sum_pipe #(.RND_MODE(1), .SAT(1)) u_sat (.clk(clk), .reset(reset), .bus(b_sat));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // one valid sample, then wait until its result is on the outputs
    task automatic send(input logic [21:0] a, input logic [38:0] b, input logic s);
        t_in1 = a; t_in2 = b; t_sub = s; t_vld = 1'b1;
        tick();
        t_vld = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; t_enb = 1'b1; t_vld = 1'b0; t_sub = 1'b0; t_clr = 1'b0;
        t_in1 = '0; t_in2 = '0;
        tick(); tick();
        n_cmp++; if (b_def.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b exp 0", b_def.out_valid); end
        n_cmp++; if (b_def.out1 !== 36'h0) begin n_err++; $display("FAIL rst_out1 got %h exp 0", b_def.out1); end
        n_cmp++; if (b_def.ovf !== 1'b0) begin n_err++; $display("FAIL rst_ovf got %b exp 0", b_def.ovf); end
        n_cmp++; if (b_def.ovf_sticky !== 1'b0) begin n_err++; $display("FAIL rst_sticky got %b exp 0", b_def.ovf_sticky); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        t_in1 = 22'd16384; t_in2 = '0; t_sub = 1'b0; t_vld = 1'b1;
        tick();
        t_vld = 1'b0;
        n_cmp++; if (b_def.out_valid !== 1'b0) begin n_err++; $display("FAIL lat1_valid got %b exp 0", b_def.out_valid); end
        tick();
        n_cmp++; if (b_def.out_valid !== 1'b1) begin n_err++; $display("FAIL lat2_valid got %b exp 1", b_def.out_valid); end
        n_cmp++; if (b_def.out1 !== 36'h008000000) begin n_err++; $display("FAIL basic_out1 got %h exp 008000000", b_def.out1); end
        n_cmp++; if (b_def.ovf !== 1'b0) begin n_err++; $display("FAIL basic_ovf got %b exp 0", b_def.ovf); end
        tick();
        n_cmp++; if (b_def.out_valid !== 1'b0) begin n_err++; $display("FAIL lat3_valid got %b exp 0", b_def.out_valid); end
        n_cmp++; if (b_def.out1 !== 36'h008000000) begin n_err++; $display("FAIL hold_out1 got %h exp 008000000", b_def.out1); end
    endtask

    task automatic test_rounding();
        send(22'd0, 39'd1, 1'b0);
        n_cmp++; if (b_flr.out1 !== 36'h0) begin n_err++; $display("FAIL rnd_floor_1 got %h exp 0", b_flr.out1); end
        n_cmp++; if (b_def.out1 !== 36'h1) begin n_err++; $display("FAIL rnd_halfup_1 got %h exp 1", b_def.out1); end
        n_cmp++; if (b_cnv.out1 !== 36'h0) begin n_err++; $display("FAIL rnd_conv_1 got %h exp 0", b_cnv.out1); end
        send(22'd0, 39'd3, 1'b0);
        n_cmp++; if (b_cnv.out1 !== 36'h2) begin n_err++; $display("FAIL rnd_conv_3 got %h exp 2", b_cnv.out1); end
        n_cmp++; if (b_flr.out1 !== 36'h1) begin n_err++; $display("FAIL rnd_floor_3 got %h exp 1", b_flr.out1); end
        send(22'd0, '1, 1'b0);
        n_cmp++; if (b_def.out1 !== 36'h0) begin n_err++; $display("FAIL rnd_halfup_m1 got %h exp 0", b_def.out1); end
        n_cmp++; if (b_flr.out1 !== 36'hFFFFFFFFF) begin n_err++; $display("FAIL rnd_floor_m1 got %h exp FFFFFFFFF", b_flr.out1); end
    endtask

    task automatic test_subtract();
        send(22'd16384, 39'h0010000000, 1'b1);
        n_cmp++; if (b_def.out1 !== 36'h0) begin n_err++; $display("FAIL sub_zero got %h exp 0", b_def.out1); end
        send(22'd0, 39'h0010000000, 1'b1);
        n_cmp++; if (b_def.out1 !== 36'hFF8000000) begin n_err++; $display("FAIL sub_neg got %h exp FF8000000", b_def.out1); end
        n_cmp++; if (b_def.ovf !== 1'b0) begin n_err++; $display("FAIL sub_ovf got %b exp 0", b_def.ovf); end
    endtask

    task automatic test_overflow();
        send(22'd0, 39'h3FFFFFFFFF, 1'b0);
        n_cmp++; if (b_sat.out1 !== 36'h7FFFFFFFF) begin n_err++; $display("FAIL sat_out1 got %h exp 7FFFFFFFF", b_sat.out1); end
        n_cmp++; if (b_sat.ovf !== 1'b1) begin n_err++; $display("FAIL sat_ovf got %b exp 1", b_sat.ovf); end
        n_cmp++; if (b_sat.ovf_sticky !== 1'b1) begin n_err++; $display("FAIL sat_sticky got %b exp 1", b_sat.ovf_sticky); end
        // rounded value is 2^37, whose low 36 bits are zero
        n_cmp++; if (b_def.out1 !== 36'h0) begin n_err++; $display("FAIL wrap_out1 got %h exp 0", b_def.out1); end
        n_cmp++; if (b_def.ovf !== 1'b1) begin n_err++; $display("FAIL wrap_ovf got %b exp 1", b_def.ovf); end
        n_cmp++; if (b_def.ovf_sticky !== 1'b1) begin n_err++; $display("FAIL wrap_sticky got %b exp 1", b_def.ovf_sticky); end
        tick();
        n_cmp++; if (b_def.ovf !== 1'b0) begin n_err++; $display("FAIL ovf_bubble got %b exp 0", b_def.ovf); end
        n_cmp++; if (b_def.ovf_sticky !== 1'b1) begin n_err++; $display("FAIL sticky_hold got %b exp 1", b_def.ovf_sticky); end
    endtask

    task automatic test_sticky_clr();
        t_clr = 1'b1;
        tick();
        t_clr = 1'b0;
        n_cmp++; if (b_def.ovf_sticky !== 1'b0) begin n_err++; $display("FAIL clr_sticky got %b exp 0", b_def.ovf_sticky); end
        n_cmp++; if (b_sat.ovf_sticky !== 1'b0) begin n_err++; $display("FAIL clr_sticky_sat got %b exp 0", b_sat.ovf_sticky); end
        t_in1 = '0; t_in2 = 39'h3FFFFFFFFF; t_sub = 1'b0; t_vld = 1'b1;
        tick();
        t_vld = 1'b0; t_clr = 1'b1;
        tick();
        t_clr = 1'b0;
        n_cmp++; if (b_def.ovf_sticky !== 1'b1) begin n_err++; $display("FAIL set_wins got %b exp 1", b_def.ovf_sticky); end
        n_cmp++; if (b_def.ovf !== 1'b1) begin n_err++; $display("FAIL set_wins_ovf got %b exp 1", b_def.ovf); end
    endtask

    task automatic test_stall();
        t_in2 = '0; t_sub = 1'b0;
        t_in1 = 22'd16384; t_vld = 1'b1;
        tick();
        t_in1 = 22'd32768;
        tick();
        n_cmp++; if (b_def.out1 !== 36'h008000000) begin n_err++; $display("FAIL stall_v0 got %h exp 008000000", b_def.out1); end
        t_enb = 1'b0; t_in1 = 22'd49152; t_clr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (b_def.out_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid[%0d] got %b exp 1", i, b_def.out_valid); end
            n_cmp++; if (b_def.out1 !== 36'h008000000) begin n_err++; $display("FAIL stall_out1[%0d] got %h exp 008000000", i, b_def.out1); end
        end
        n_cmp++; if (b_def.ovf_sticky !== 1'b1) begin n_err++; $display("FAIL stall_clr_ignored got %b exp 1", b_def.ovf_sticky); end
        t_clr = 1'b0; t_enb = 1'b1;
        tick();
        n_cmp++; if (b_def.out1 !== 36'h010000000) begin n_err++; $display("FAIL stall_v1 got %h exp 010000000", b_def.out1); end
        t_in1 = 22'd65536;
        tick();
        n_cmp++; if (b_def.out1 !== 36'h018000000) begin n_err++; $display("FAIL stall_v2 got %h exp 018000000", b_def.out1); end
        t_vld = 1'b0;
        tick();
        n_cmp++; if (b_def.out1 !== 36'h020000000 || b_def.out_valid !== 1'b1) begin n_err++; $display("FAIL stall_v3 got %h/%b exp 020000000/1", b_def.out1, b_def.out_valid); end
        tick();
        n_cmp++; if (b_def.out_valid !== 1'b0) begin n_err++; $display("FAIL stall_end got %b exp 0", b_def.out_valid); end
        t_clr = 1'b1;
        tick();
        t_clr = 1'b0;
    endtask

    task automatic test_reset_mid();
        t_in2 = '0; t_sub = 1'b0;
        t_in1 = 22'd81920; t_vld = 1'b1;
        tick();
        t_in1 = 22'd98304;
        tick();
        n_cmp++; if (b_def.out1 !== 36'h028000000 || b_def.out_valid !== 1'b1) begin n_err++; $display("FAIL pre_rst got %h/%b exp 028000000/1", b_def.out1, b_def.out_valid); end
        t_in1 = 22'd114688;
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (b_def.out_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid got %b exp 0", b_def.out_valid); end
        n_cmp++; if (b_def.out1 !== 36'h0) begin n_err++; $display("FAIL mid_rst_out1 got %h exp 0", b_def.out1); end
        t_vld = 1'b0;
        tick(); tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (b_def.out_valid !== 1'b0) begin n_err++; $display("FAIL post_rst_valid[%0d] got %b exp 0", i, b_def.out_valid); end
        end
        t_in1 = 22'd32768; t_vld = 1'b1;
        tick();
        t_vld = 1'b0;
        n_cmp++; if (b_def.out_valid !== 1'b0) begin n_err++; $display("FAIL post_rst_lat1 got %b exp 0", b_def.out_valid); end
        tick();
        n_cmp++; if (b_def.out_valid !== 1'b1 || b_def.out1 !== 36'h010000000) begin n_err++; $display("FAIL post_rst_lat2 got %b/%h exp 1/010000000", b_def.out_valid, b_def.out1); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_subtract();
        test_overflow();
        test_sticky_clr();
        test_stall();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fxp_sum_pipe.md
# fxp_sum_pipe

Parametrised, pipelined fixed-point two-operand adder/subtractor for the IIR filter datapath. It is the generic successor to the fixed-format sum blocks. Operand and result Q-formats are set by parameters. It adds selectable rounding (floor, half-up or convergent), selectable overflow handling (wrap or saturate), a valid/enable handshake and overflow reporting. It sits between the coefficient multipliers and the state registers of each biquad section.

## Interface
- W_A, 22: in1 total width (signed)
- F_A, 14: in1 fraction bits
- W_B, 39: in2 total width (signed)
- F_B, 28: in2 fraction bits
- W_O, 36: out1 total width (signed)
- F_O, 27: out1 fraction bits
- RND_MODE, 1: 0 = floor (truncate), 1 = round half up, 2 = convergent (round half to even)
- SAT, 0: 0 = wrap on overflow, 1 = saturate to the W_O range

- clk  in  1  clock; all registers update on the rising edge.
- reset  in  1  asynchronous, active-high; clears all registers.
- enb  in  1  clock enable; when 0, every register holds.
- in_valid  in  1  in1/in2/sub carry a sample this cycle.
- in1  in  W_A  operand A, sfix W_A_En F_A
- in2  in  W_B  operand B, sfix W_B_En F_B
- sub  in  1  0: out1 = in1 + in2; 1: out1 = in1 − in2
- ovf_clr  in  1  clears ovf_sticky
- out_valid  out  1  out1/ovf carry a result
- out1  out  W_O  result, sfix W_O_En F_O
- ovf  out  1  the current result overflowed W_O; forced to 0 when out_valid = 0
- ovf_sticky  out  1  set by any overflowing result; held until cleared

## Operation
- Internal full-precision format:
  - FI = max(F_A, F_B)
  - II = max(W_A−F_A, W_B−F_B) + 1
  - WI = II + FI
- Stage 1 (registered):
  - Sign-extend both operands and left-align them to FI.
  - Compute the sum or difference in WI bits. This step is exact and never overflows.
  - Register the result with the valid bit.
- Stage 2 (registered):
  - If F_O ≥ FI: left-shift by F_O−FI. This is exact.
  - Otherwise, drop D = FI−F_O LSBs:
    - Floor: discard the dropped bits.
    - Half-up: add dropped bit D−1.
    - Convergent: add bit D−1 unless the dropped bits equal exactly one half and the kept LSB is 0.
  - Compute the rounding increment in WI+1 bits so that rounding itself cannot wrap.
- Narrowing to W_O:
  - Overflow = the rounded value lies outside [−2^(W_O−1), 2^(W_O−1)−1] in units of 2^−F_O.
  - SAT = 1: clamp to the nearest bound.
  - SAT = 0: keep the low W_O bits (two's-complement wrap).
  - In both modes ovf = 1 for that result.
- Register update:
  - out1 loads only on valid stage-2 data and holds its last value otherwise.
  - ovf_sticky is set by an overflowing valid result.
  - ovf_sticky is cleared by ovf_clr.
  - If a set and a clear occur in the same enabled cycle, the set wins.

## Timing
- Latency is 2 enabled cycles from in_valid to out_valid, with throughput of one sample per cycle.
- enb = 0 freezes both stages, out_valid, out1 and ovf_sticky. ovf_clr is ignored while enb = 0.
- Reset values: out_valid = 0, out1 = 0, ovf = 0, ovf_sticky = 0, and both stage registers = 0.
- When reset asserts mid-stream, in-flight samples are discarded. The first in_valid after deassertion appears 2 enabled cycles later.
- Back-to-back valids and gaps are supported. Bubbles propagate as out_valid = 0.

## Structure
- Shared package fxp_pkg holds:
  - rounding-mode constants RND_FLOOR = 0, RND_HALF_UP = 1, RND_CONVERGENT = 2
  - a constant function imax() for the width derivations
- The stage-2 narrowing logic (rounding, saturation/wrap, overflow detection) goes in the combinational sub-module fxp_round_sat. Its parameters are WI, FI, W_O, F_O, RND_MODE and SAT. Other blocks will reuse it.
- fxp_sum_pipe contains the alignment, the adder and both pipeline register stages.

## Test plan
- **Basic add, latency and reset:** defaults, in1 = 16384 (1.0), in2 = 0, in_valid one cycle → out1 = 36'h008000000 with out_valid exactly 2 cycles later, ovf = 0.
- **Rounding modes:** in1 = 0, with D = 1 (FI = 28, F_O = 27):
  - in2 = 1, RND_MODE = 0/1/2 → out1 = 0 / 1 / 0.
  - in2 = 3, RND_MODE = 2 → out1 = 2.
  - in2 = −1, RND_MODE = 1 → out1 = 0.
- **Subtract:** in1 = 16384, in2 = 2^28, sub = 1 → out1 = 0. Then in1 = 0, in2 = 2^28, sub = 1 → out1 = −2^27.
- **Overflow, saturate:** SAT = 1, in1 = 0, in2 = 2^38−1 → out1 = 36'h7FFFFFFFF, ovf = 1, ovf_sticky = 1.
- **Overflow, wrap and sticky clear:**
  - Same stimulus with SAT = 0 → out1 = low 36 bits of the rounded value, ovf = 1.
  - ovf_clr pulsed in a cycle with no overflowing result → ovf_sticky returns to 0.
  - ovf_clr pulsed in the same cycle as an overflowing result → ovf_sticky stays 1.
- **Stall and reset mid-stream:**
  - Drive 4 consecutive valid samples and drop enb for 3 cycles mid-stream → outputs freeze, then resume in order with no loss or duplication.
  - Assert reset with 2 samples in flight → out_valid drops immediately, and those samples never appear.
